// File: rtl/alu_pkg.sv
// Shared definitions for the UART <-> ALU glue logic and its bench.
// Contents: default data/opcode widths, the ALU opcode values, and the state
// encoding of the uart_alu_interface FSM.
package alu_pkg;

    localparam int DEF_NB_DATA = 8;
    localparam int DEF_NB_OP   = 6;

    localparam logic [DEF_NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [DEF_NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [DEF_NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [DEF_NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [DEF_NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [DEF_NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [DEF_NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [DEF_NB_OP-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5,
        ST_SEND_ST = 3'd6,
        ST_WAIT_ST = 3'd7
    } state_t;

endpackage

// File: rtl/uart_alu_interface.sv
// Glue FSM between UART RX/TX and the combinational 8-bit ALU.
// Collects operand A, operand B and the opcode from RX, lets the ALU settle
// for one cycle, captures result (and flags), and hands the result byte to TX
// with a start/done handshake.
//
// Optional feature macro: UART_ALU_STATUS_BYTE_EN
//   defined   -> a second byte {0.., carry, zero} follows every result byte.
//   undefined -> one result byte per transaction.
//
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_rx_data, i_rx_done     RX byte and its one-cycle strobe
//   i_tx_done                TX finished current byte (one-cycle strobe)
//   i_alu_result/carry/zero  ALU outputs
//   o_data_a/o_data_b/o_op   registered ALU inputs
//   o_tx_data, o_tx_start    TX byte and start pulse
//   o_busy                   high while a result is being computed/sent
//   o_rx_overrun             sticky: an RX byte was dropped while busy
//
// state      | meaning
// WAIT_A     | idle, waiting for operand A
// WAIT_B     | waiting for operand B
// WAIT_OP    | waiting for opcode
// EXEC       | ALU inputs settled, capture result
// SEND       | o_tx_start high for result byte
// WAIT_TX    | waiting for TX to finish result byte
// SEND_ST    | o_tx_start high for status byte (feature only)
// WAIT_ST    | waiting for TX to finish status byte (feature only)
module uart_alu_interface
    import alu_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_OP   = DEF_NB_OP
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_carry,
    input  logic               i_alu_zero,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_rx_overrun
);

    state_t state;

`ifdef UART_ALU_STATUS_BYTE_EN
    logic carry_q;
    logic zero_q;
`else
    // Flags are only needed for the status byte.
    logic flags_unused;
    assign flags_unused = i_alu_carry | i_alu_zero;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_WAIT_A;
            o_data_a     <= '0;
            o_data_b     <= '0;
            o_op         <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_busy       <= 1'b0;
            o_rx_overrun <= 1'b0;
`ifdef UART_ALU_STATUS_BYTE_EN
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
`endif
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                ST_WAIT_A: begin
                    if (i_rx_done) begin
                        o_data_a <= i_rx_data;
                        state    <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (i_rx_done) begin
                        o_data_b <= i_rx_data;
                        state    <= ST_WAIT_OP;
                    end
                end
                ST_WAIT_OP: begin
                    if (i_rx_done) begin
                        o_op   <= i_rx_data[NB_OP-1:0];
                        o_busy <= 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    o_tx_data  <= i_alu_result;
`ifdef UART_ALU_STATUS_BYTE_EN
                    carry_q    <= i_alu_carry;
                    zero_q     <= i_alu_zero;
`endif
                    // Start is registered, so it is raised on entry to SEND.
                    o_tx_start <= 1'b1;
                    state      <= ST_SEND;
                    if (i_rx_done) o_rx_overrun <= 1'b1;
                end
                ST_SEND: begin
                    state <= ST_WAIT_TX;
                    if (i_rx_done) o_rx_overrun <= 1'b1;
                end
`ifdef UART_ALU_STATUS_BYTE_EN
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        o_tx_data  <= {{(NB_DATA-2){1'b0}}, carry_q, zero_q};
                        o_tx_start <= 1'b1;
                        state      <= ST_SEND_ST;
                    end
                    // Still busy with the status byte, so any RX is dropped.
                    if (i_rx_done) o_rx_overrun <= 1'b1;
                end
                ST_SEND_ST: begin
                    state <= ST_WAIT_ST;
                    if (i_rx_done) o_rx_overrun <= 1'b1;
                end
                ST_WAIT_ST: begin
`else
                ST_WAIT_TX: begin
`endif
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        // A byte landing with the final done starts the next transaction.
                        if (i_rx_done) begin
                            o_data_a <= i_rx_data;
                            state    <= ST_WAIT_B;
                        end else begin
                            state    <= ST_WAIT_A;
                        end
                    end else if (i_rx_done) begin
                        o_rx_overrun <= 1'b1;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_WAIT_A;
                end
            endcase
        end
    end

endmodule
